// File: rtl/mul_int_pipe.sv
// mul_int_pipe: multi-lane pipelined signed integer multiplier with a per-lane
// saturating accumulator, valid/ready handshake and whole-pipe backpressure.
// Sits between MX element decode and block-scale/reduction.
//
// Parameters
//   bit_width  operand width per lane (signed)
//   prd_width  product width per lane (>= 2*bit_width)
//   acc_width  accumulator width per lane (>= prd_width)
//   LANES      number of independent lanes
//   PIPE       input-to-output latency in cycles (>= 1)
//   USE_DSP    "yes" | "logic" | "auto" multiplier mapping hint
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       input handshake (o_ready is combinational)
//   i_op0, i_op1            lane k operand = [k*bit_width +: bit_width]
//   i_acc_en, i_acc_clr     accumulator control, travels with the beat
//   o_valid / i_ready       output handshake
//   o_prd                   per-lane exact signed product of the output beat
//   o_acc                   per-lane accumulator after the output beat
//   o_ovf                   per-lane sticky saturation flag
module mul_int_pipe #(
    parameter int unsigned bit_width = 8,
    parameter int unsigned prd_width = 2 * bit_width,
    parameter int unsigned acc_width = prd_width + 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned PIPE      = 2,
    parameter string       USE_DSP   = "auto"
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [LANES*bit_width-1:0]   i_op0,
    input  logic [LANES*bit_width-1:0]   i_op1,
    input  logic                         i_acc_en,
    input  logic                         i_acc_clr,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [LANES*prd_width-1:0]   o_prd,
    output logic [LANES*acc_width-1:0]   o_acc,
    output logic [LANES-1:0]             o_ovf
);
    localparam int unsigned FW = 2 * bit_width;       // full-precision product width
    localparam int unsigned PV = LANES * prd_width;   // packed product vector width

    // Elaboration-time parameter checks
    if (prd_width < FW) begin : g_chk_prd
        $error("mul_int_pipe: prd_width must be >= 2*bit_width");
    end
    if (acc_width < prd_width) begin : g_chk_acc
        $error("mul_int_pipe: acc_width must be >= prd_width");
    end
    if (PIPE < 1) begin : g_chk_pipe
        $error("mul_int_pipe: PIPE must be >= 1");
    end
    if (USE_DSP != "yes" && USE_DSP != "logic" && USE_DSP != "auto") begin : g_chk_dsp
        $error("mul_int_pipe: USE_DSP must be yes, logic or auto");
    end

    // Global advance: the whole pipe moves unless a held output beat is refused
    logic w_en;
    assign w_en    = !o_valid || i_ready;
    assign o_ready = w_en;

    // Per-lane full-precision products, sign-extended to prd_width
    logic [PV-1:0] w_prd_in;

    for (genvar k = 0; k < LANES; k++) begin : g_mul
        logic signed [bit_width-1:0] w_a;
        logic signed [bit_width-1:0] w_b;
        logic signed [FW-1:0]        w_full;

        assign w_a = i_op0[k*bit_width +: bit_width];
        assign w_b = i_op1[k*bit_width +: bit_width];

        if (USE_DSP == "yes") begin : g_sm
            // Sign/magnitude form: the most-negative operand's magnitude still
            // fits in bit_width unsigned bits, so no extra bit is needed.
            logic [bit_width-1:0] w_ma;
            logic [bit_width-1:0] w_mb;
            logic [FW-1:0]        w_mp;
            logic                 w_neg;

            assign w_ma   = w_a[bit_width-1] ? bit_width'(-w_a) : w_a;
            assign w_mb   = w_b[bit_width-1] ? bit_width'(-w_b) : w_b;
            assign w_mp   = FW'(w_ma) * FW'(w_mb);
            assign w_neg  = w_a[bit_width-1] ^ w_b[bit_width-1];
            assign w_full = w_neg ? FW'(-w_mp) : w_mp;
        end else begin : g_direct
            assign w_full = FW'(w_a) * FW'(w_b);
        end

        assign w_prd_in[k*prd_width +: prd_width] = prd_width'(w_full);
    end

    // Pipeline stages; stage PIPE-1 is the output stage
    logic [PIPE-1:0] r_vld;
    logic [PIPE-1:0] r_aen;
    logic [PIPE-1:0] r_aclr;
    logic [PV-1:0]   r_prd [PIPE];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld  <= '0;
            r_aen  <= '0;
            r_aclr <= '0;
            for (int s = 0; s < int'(PIPE); s++) begin
                r_prd[s] <= '0;
            end
        end else if (w_en) begin
            r_vld[0]  <= i_valid;
            r_aen[0]  <= i_acc_en;
            r_aclr[0] <= i_acc_clr;
            r_prd[0]  <= w_prd_in;
            for (int s = 1; s < int'(PIPE); s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_aen[s]  <= r_aen[s-1];
                r_aclr[s] <= r_aclr[s-1];
                r_prd[s]  <= r_prd[s-1];
            end
        end
    end

    assign o_valid = r_vld[PIPE-1];
    assign o_prd   = r_prd[PIPE-1];

    // Beat about to enter the output stage
    logic          w_last_vld;
    logic          w_last_aen;
    logic          w_last_aclr;
    logic [PV-1:0] w_last_prd;

    if (PIPE == 1) begin : g_last_in
        assign w_last_vld  = i_valid;
        assign w_last_aen  = i_acc_en;
        assign w_last_aclr = i_acc_clr;
        assign w_last_prd  = w_prd_in;
    end else begin : g_last_pipe
        assign w_last_vld  = r_vld[PIPE-2];
        assign w_last_aen  = r_aen[PIPE-2];
        assign w_last_aclr = r_aclr[PIPE-2];
        assign w_last_prd  = r_prd[PIPE-2];
    end

    // Accumulators change only when a valid beat moves into the output stage
    logic w_upd;
    assign w_upd = w_en && w_last_vld;

    for (genvar k = 0; k < LANES; k++) begin : g_acc
        logic signed [acc_width-1:0] r_acc;
        logic signed [acc_width-1:0] w_acc_nxt;
        logic signed [acc_width-1:0] w_ext;
        logic signed [acc_width:0]   w_sum;
        logic                        r_ovf;
        logic                        w_ovf_nxt;

        assign w_ext = acc_width'($signed(w_last_prd[k*prd_width +: prd_width]));
        assign w_sum = (acc_width+1)'(r_acc) + (acc_width+1)'(w_ext);

        // Next accumulator value; overflow shows as disagreeing top two sum bits
        always_comb begin
            w_acc_nxt = r_acc;
            w_ovf_nxt = r_ovf;
            if (w_upd) begin
                case ({w_last_aen, w_last_aclr})
                    2'b11: begin
                        w_acc_nxt = w_ext;
                        w_ovf_nxt = 1'b0;
                    end
                    2'b10: begin
                        if (w_sum[acc_width] != w_sum[acc_width-1]) begin
                            w_acc_nxt = w_sum[acc_width] ? {1'b1, {(acc_width-1){1'b0}}}
                                                         : {1'b0, {(acc_width-1){1'b1}}};
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_acc_nxt = w_sum[acc_width-1:0];
                        end
                    end
                    2'b01: begin
                        w_acc_nxt = '0;
                        w_ovf_nxt = 1'b0;
                    end
                    default: begin
                        w_acc_nxt = r_acc;
                        w_ovf_nxt = r_ovf;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_acc_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end

        assign o_acc[k*acc_width +: acc_width] = r_acc;
        assign o_ovf[k]                        = r_ovf;
    end

endmodule

// File: tb/tb_mul_int_pipe.sv
// tb_mul_int_pipe: self-checking bench for mul_int_pipe. Three instances share
// the same inputs (PIPE 2/1/3, USE_DSP yes/auto/logic, acc_width 16); each has
// its own expected-result queue and accumulator reference.
module tb_mul_int_pipe;
    localparam int ND = 3;
    localparam int LN = 4;

    typedef struct {
        logic [63:0] prd;
        logic [63:0] acc;
        logic [3:0]  ovf;
    } exp_t;

    typedef struct {
        logic [31:0] op0;
        logic [31:0] op1;
        bit          aen;
        bit          aclr;
        logic [63:0] prd;
        logic [63:0] acc;
        logic [3:0]  ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic        i_acc_en;
    logic        i_acc_clr;
    logic [31:0] op0;
    logic [31:0] op1;

    logic        w_rdy  [ND];
    logic        w_ovld [ND];
    logic [63:0] w_prd  [ND];
    logic [63:0] w_acc  [ND];
    logic [3:0]  w_ovf  [ND];

    mul_int_pipe #(.bit_width(8), .prd_width(16), .acc_width(16), .LANES(4), .PIPE(2), .USE_DSP("yes")) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(w_rdy[0]),
        .i_op0(op0), .i_op1(op1), .i_acc_en(i_acc_en), .i_acc_clr(i_acc_clr),
        .o_valid(w_ovld[0]), .i_ready(i_ready), .o_prd(w_prd[0]), .o_acc(w_acc[0]), .o_ovf(w_ovf[0]));

    mul_int_pipe #(.bit_width(8), .prd_width(16), .acc_width(16), .LANES(4), .PIPE(1), .USE_DSP("auto")) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(w_rdy[1]),
        .i_op0(op0), .i_op1(op1), .i_acc_en(i_acc_en), .i_acc_clr(i_acc_clr),
        .o_valid(w_ovld[1]), .i_ready(i_ready), .o_prd(w_prd[1]), .o_acc(w_acc[1]), .o_ovf(w_ovf[1]));

    mul_int_pipe #(.bit_width(8), .prd_width(16), .acc_width(16), .LANES(4), .PIPE(3), .USE_DSP("logic")) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(w_rdy[2]),
        .i_op0(op0), .i_op1(op1), .i_acc_en(i_acc_en), .i_acc_clr(i_acc_clr),
        .o_valid(w_ovld[2]), .i_ready(i_ready), .o_prd(w_prd[2]), .o_acc(w_acc[2]), .o_ovf(w_ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        sbq [ND][$];
    longint      m_acc [ND][LN];
    bit          m_ovf [ND][LN];
    int          n_in  [ND];
    int          n_out [ND];
    bit          hold_prev [ND];
    logic [63:0] hold_prd  [ND];
    logic [63:0] hold_acc  [ND];
    logic [3:0]  hold_ovf  [ND];
    bit          use_tab = 1'b0;
    vec_t        cur;
    vec_t        tab [12];

    function automatic int pipe_of(int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 3;
    endfunction

    function automatic logic [31:0] pack8(int a0, int a1, int a2, int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [63:0] pack16(int a0, int a1, int a2, int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // Integer reference: exact product, clamped 16-bit accumulator, sticky flag
    function automatic exp_t model(int d, logic [31:0] a, logic [31:0] b, bit aen, bit aclr);
        exp_t   e;
        longint p;
        longint s;
        e.prd = '0;
        e.acc = '0;
        e.ovf = '0;
        for (int l = 0; l < LN; l++) begin
            p = longint'($signed(a[l*8 +: 8])) * longint'($signed(b[l*8 +: 8]));
            if (aen && aclr) begin
                m_acc[d][l] = p;
                m_ovf[d][l] = 1'b0;
            end else if (aen) begin
                s = m_acc[d][l] + p;
                if (s > 32767) begin
                    s = 32767;
                    m_ovf[d][l] = 1'b1;
                end else if (s < -32768) begin
                    s = -32768;
                    m_ovf[d][l] = 1'b1;
                end
                m_acc[d][l] = s;
            end else if (aclr) begin
                m_acc[d][l] = 0;
                m_ovf[d][l] = 1'b0;
            end
            e.prd[l*16 +: 16] = 16'(p);
            e.acc[l*16 +: 16] = 16'(m_acc[d][l]);
            e.ovf[l]          = m_ovf[d][l];
        end
        return e;
    endfunction

    task automatic reset_model();
        for (int d = 0; d < ND; d++) begin
            sbq[d].delete();
            hold_prev[d] = 1'b0;
            n_in[d]  = 0;
            n_out[d] = 0;
            for (int l = 0; l < LN; l++) begin
                m_acc[d][l] = 0;
                m_ovf[d][l] = 1'b0;
            end
        end
    endtask

    // Called #1 after the driving negedge: handshakes resolve at the next posedge
    task automatic monitor();
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            if (hold_prev[d]) begin
                chk("hold_prd", d, w_prd[d], hold_prd[d]);
                chk("hold_acc", d, w_acc[d], hold_acc[d]);
                chk("hold_ovf", d, 64'(w_ovf[d]), 64'(hold_ovf[d]));
            end
            if (w_ovld[d] && i_ready) begin
                if (sbq[d].size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat dut%0d: got prd %h, expected no beat", d, w_prd[d]);
                end else begin
                    e = sbq[d].pop_front();
                    chk("prd", d, w_prd[d], e.prd);
                    chk("acc", d, w_acc[d], e.acc);
                    chk("ovf", d, 64'(w_ovf[d]), 64'(e.ovf));
                    n_out[d]++;
                end
            end
            hold_prev[d] = w_ovld[d] && !i_ready;
            hold_prd[d]  = w_prd[d];
            hold_acc[d]  = w_acc[d];
            hold_ovf[d]  = w_ovf[d];
            if (i_valid && w_rdy[d]) begin
                e = model(d, op0, op1, i_acc_en, i_acc_clr);
                if (use_tab) begin
                    e.prd = cur.prd;
                    e.acc = cur.acc;
                    e.ovf = cur.ovf;
                end
                sbq[d].push_back(e);
                n_in[d]++;
            end
        end
    endtask

    task automatic cyc_pre();
        #1;
    endtask

    task automatic cyc_post();
        monitor();
        @(negedge clk);
    endtask

    task automatic cycle();
        cyc_pre();
        cyc_post();
    endtask

    task automatic drain();
        int t;
        i_valid = 1'b0;
        i_ready = 1'b1;
        t = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && t < 50) begin
            cycle();
            t++;
        end
        for (int d = 0; d < ND; d++) begin
            chk("drain_left", d, 64'(sbq[d].size()), 64'd0);
            chk("beat_count", d, 64'(n_out[d]), 64'(n_in[d]));
        end
        repeat (3) cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bv;
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_acc_en  = 1'b0;
        i_acc_clr = 1'b0;
        op0       = '0;
        op1       = '0;
        reset_model();

        // Corner products and saturating accumulation, lane0 low byte
        tab[0]  = '{pack8(-128,-128,0,127), pack8(-128,127,-1,127), 1, 1,
                    pack16(16384,-16256,0,16129), pack16(16384,-16256,0,16129), 4'b0000};
        tab[1]  = '{pack8(-128,-128,0,127), pack8(-128,127,-1,127), 1, 0,
                    pack16(16384,-16256,0,16129), pack16(32767,-32512,0,32258), 4'b0001};
        tab[2]  = '{pack8(-128,-128,0,127), pack8(-128,127,-1,127), 1, 0,
                    pack16(16384,-16256,0,16129), pack16(32767,-32768,0,32767), 4'b1011};
        tab[3]  = '{pack8(3,3,3,3), pack8(-5,-5,-5,-5), 0, 0,
                    pack16(-15,-15,-15,-15), pack16(32767,-32768,0,32767), 4'b1011};
        tab[4]  = '{pack8(2,2,2,2), pack8(3,3,3,3), 1, 1,
                    pack16(6,6,6,6), pack16(6,6,6,6), 4'b0000};
        tab[5]  = '{pack8(-1,5,-128,127), pack8(1,-7,1,-128), 1, 0,
                    pack16(-1,-35,-128,-16256), pack16(5,-29,-122,-16250), 4'b0000};
        tab[6]  = '{pack8(0,0,0,0), pack8(0,0,0,0), 0, 1,
                    pack16(0,0,0,0), pack16(0,0,0,0), 4'b0000};
        tab[7]  = '{pack8(127,1,-2,100), pack8(127,-1,-3,-100), 1, 1,
                    pack16(16129,-1,6,-10000), pack16(16129,-1,6,-10000), 4'b0000};
        tab[8]  = '{pack8(127,1,-2,100), pack8(127,-1,-3,-100), 1, 0,
                    pack16(16129,-1,6,-10000), pack16(32258,-2,12,-20000), 4'b0000};
        tab[9]  = '{pack8(127,1,-2,100), pack8(127,-1,-3,-100), 1, 0,
                    pack16(16129,-1,6,-10000), pack16(32767,-3,18,-30000), 4'b0001};
        tab[10] = '{pack8(127,1,-2,100), pack8(127,-1,-3,-100), 1, 0,
                    pack16(16129,-1,6,-10000), pack16(32767,-4,24,-32768), 4'b1001};
        tab[11] = '{pack8(2,2,2,2), pack8(3,3,3,3), 1, 1,
                    pack16(6,6,6,6), pack16(6,6,6,6), 4'b0000};

        // Reset state
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_valid", d, 64'(w_ovld[d]), 64'd0);
            chk("rst_prd", d, w_prd[d], 64'd0);
            chk("rst_acc", d, w_acc[d], 64'd0);
            chk("rst_ovf", d, 64'(w_ovf[d]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc_pre();
        for (int d = 0; d < ND; d++) chk("ready_init", d, 64'(w_rdy[d]), 64'd1);
        cyc_post();

        // Table vectors
        use_tab = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cur       = tab[i];
            op0       = cur.op0;
            op1       = cur.op1;
            i_acc_en  = cur.aen;
            i_acc_clr = cur.aclr;
            i_valid   = 1'b1;
            cycle();
        end
        use_tab = 1'b0;
        drain();

        // Asynchronous reset with beats in flight
        op0 = pack8(1,1,1,1);
        op1 = pack8(1,1,1,1);
        i_acc_en  = 1'b1;
        i_acc_clr = 1'b0;
        i_valid   = 1'b1;
        cycle();
        cycle();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("midrst_valid", d, 64'(w_ovld[d]), 64'd0);
            chk("midrst_acc", d, w_acc[d], 64'd0);
            chk("midrst_ovf", d, 64'(w_ovf[d]), 64'd0);
        end
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc_pre();
            for (int d = 0; d < ND; d++) begin
                chk("no_stale", d, 64'(w_ovld[d]), 64'd0);
                if (c == 0) chk("ready_after_rst", d, 64'(w_rdy[d]), 64'd1);
            end
            cyc_post();
        end

        // Streaming latency: 8 back-to-back beats of 3*-5
        op0 = pack8(3,3,3,3);
        op1 = pack8(-5,-5,-5,-5);
        i_acc_en  = 1'b0;
        i_acc_clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            i_valid = (i < 8);
            cyc_pre();
            for (int d = 0; d < ND; d++)
                chk("lat_valid", d, 64'(w_ovld[d]), 64'((i >= pipe_of(d)) && (i < pipe_of(d) + 8)));
            cyc_post();
        end
        drain();

        // Backpressure: 3 free beats, then 5 cycles refused with i_valid held
        i_acc_en  = 1'b1;
        i_acc_clr = 1'b0;
        i_valid   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op0     = $urandom();
            op1     = $urandom();
            i_ready = !(i >= 3 && i < 8);
            cyc_pre();
            if (!i_ready)
                for (int d = 0; d < ND; d++) chk("bp_ready", d, 64'(w_rdy[d]), 64'd0);
            cyc_post();
        end
        drain();

        // Random traffic with extreme-biased operands
        for (int i = 0; i < 3000; i++) begin
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 3) != 0);
            i_acc_en  = ($urandom_range(0, 3) != 0);
            i_acc_clr = ($urandom_range(0, 15) == 0);
            for (int l = 0; l < LN; l++) begin
                case ($urandom_range(0, 5))
                    0:       bv = 8'h80;
                    1:       bv = 8'h7f;
                    default: bv = 8'($urandom());
                endcase
                op0[l*8 +: 8] = bv;
                case ($urandom_range(0, 5))
                    0:       bv = 8'h80;
                    1:       bv = 8'h7f;
                    default: bv = 8'($urandom());
                endcase
                op1[l*8 +: 8] = bv;
            end
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
